seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle 32-bit integer divider for the MIPS ALU, covering DIV and DIVU.
- Where the adder chain builds sums, this block undoes products: one restoring shift-and-subtract iteration per clock.
- Results go to the HI/LO registers: remainder to HI, quotient to LO.
- The pipeline stalls on busy and captures results on done.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request a division; sampled only while busy=0
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- dividend  in  WIDTH  numerator; sampled with start
- divisor  in  WIDTH  denominator; sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: results valid
- quotient  out  WIDTH  LO result
- remainder  out  WIDTH  HI result
- div_by_zero  out  1  divisor was zero; valid with done, held until the next done

Behaviour:
- Reset: state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0; iteration counter=0.
- Reset has priority over all other inputs and aborts an operation in progress. The next cycle is IDLE with all outputs as above.
- States:
  - IDLE: start=1 latches operands, sign flags, |dividend| and |divisor| (magnitudes only when is_signed=1). Sets partial remainder R=0, Q=|dividend|, count=0, busy=1, then goes to RUN. start=0 stays in IDLE.
  - RUN: each edge shifts {R,Q} left by 1 and computes trial T = R' - |divisor| at WIDTH+1 bits.
    - No borrow: R=T and Q[0]=1.
    - Borrow: R kept and Q[0]=0.
    - count increments; after iteration WIDTH (count=WIDTH-1 at the edge), go to FIX.
  - FIX: applies the sign rules below, registers quotient and remainder, sets done=1 and busy=0, then goes to IDLE.
- Latency: start sampled at edge E0; RUN occupies edges E1..E_WIDTH; done=1 after edge E_(WIDTH+1). With WIDTH=32, busy is high for exactly 33 cycles.
- done is high for exactly one cycle, with busy=0 in that cycle.
- start is accepted in the done cycle, giving back-to-back operation with no gap.
- start while busy=1 is ignored; operands are not re-sampled.
- quotient, remainder and div_by_zero change only on the FIX edge or on reset, and hold their values otherwise.
- Signed rules (is_signed=1, divisor≠0):
  - quotient is negated iff the operand signs differ.
  - remainder takes the sign of the dividend.
  - |x| of 0x80000000 is 0x80000000, treated as unsigned 2^31.
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0, a wrapped result with no flag.
- Divide by zero, both modes:
  - Latency is unchanged.
  - div_by_zero=1, quotient = all ones, remainder = original dividend (unnegated).
  - FIX forces these values regardless of sign handling.
- Trial subtraction is WIDTH+1 bits wide so R' ≥ 2^31 cases are correct with no overflow.

Decomposition:
- Shared package holds:
  - the state encodings IDLE=2'd0, RUN=2'd1, FIX=2'd2;
  - WIDTH;
  - the counter width, clog2(WIDTH).
- One sub-module, div_trial_sub: combinational WIDTH+1-bit subtractor, a ripple chain of the team's full-adder cell with inverted subtrahend and carry-in 1. It outputs the difference and borrow (borrow = not carry-out).
- The FSM, shift registers and sign fix-up stay in seq_divider.

Test Plan:
- Unsigned 100 / 7, is_signed=0 -> busy high 33 cycles; done pulse on the 33rd edge after start; quotient=14, remainder=2, div_by_zero=0.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; 7 / -2 -> quotient=0xFFFFFFFD, remainder=0x00000001.
- Divisor 0, dividend 0x12345678, both modes -> done after 33 cycles; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned 0xFFFFFFFF / 1 issued with start in the preceding done cycle -> accepted immediately, quotient=0xFFFFFFFF, remainder=0.
- Start pulsed again at RUN iteration 5 with different operands -> ignored, original result delivered. Reset at iteration 10 -> next cycle busy=0, done=0, outputs 0, and no done pulse appears. A fresh 9/3 then gives quotient=3, remainder=0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and constants for the sequential divider
package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/div_trial_sub.sv
// rtl/div_trial_sub.sv - ripple-carry trial subtractor (a - b) with borrow out
module div_trial_sub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] carry;

    // a - b as a + ~b + 1; a missing carry-out means the subtraction borrowed
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (~b[i]),
            .cin  (carry[i]),
            .sum  (diff[i]),
            .cout (carry[i+1])
        );
    end

    assign borrow = ~carry[W];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full-adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring shift-and-subtract divider, one bit per clock
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   r, q;
    logic [WIDTH-1:0]   dvs_mag, dvd_orig;
    logic               neg_q, neg_r, dvs_zero;

    logic [WIDTH:0]     r_shift, trial_diff;
    logic               trial_borrow;
    logic               trial_msb_unused;

    // Shifted partial remainder can reach 2^WIDTH, hence the extra bit
    assign r_shift = {r, q[WIDTH-1]};

    div_trial_sub #(.W(WIDTH + 1)) u_trial (
        .a      (r_shift),
        .b      ({1'b0, dvs_mag}),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    // On no-borrow the difference is below the divisor, so its top bit is always 0
    assign trial_msb_unused = trial_diff[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (count == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            r           <= '0;
            q           <= '0;
            dvs_mag     <= '0;
            dvd_orig    <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dvs_zero    <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        r        <= '0;
                        q        <= (is_signed && dividend[WIDTH-1]) ? ('0 - dividend) : dividend;
                        dvs_mag  <= (is_signed && divisor[WIDTH-1]) ? ('0 - divisor) : divisor;
                        dvd_orig <= dividend;
                        dvs_zero <= (divisor == '0);
                        neg_q    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r    <= is_signed && dividend[WIDTH-1];
                        count    <= '0;
                    end
                end
                RUN: begin
                    r     <= trial_borrow ? r_shift[WIDTH-1:0] : trial_diff[WIDTH-1:0];
                    q     <= {q[WIDTH-2:0], ~trial_borrow};
                    count <= count + 1'b1;
                end
                FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= dvs_zero;
                    if (dvs_zero) begin
                        quotient  <= '1;
                        remainder <= dvd_orig;
                    end else begin
                        quotient  <= neg_q ? ('0 - q) : q;
                        remainder <= neg_r ? ('0 - r) : r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    seq_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
                check("busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    // Called at a negedge; returns one cycle after the start edge
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] eq, input logic [31:0] er,
                         input logic edz);
        exp_t e;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        if (push) begin
            e.q = eq;
            e.r = er;
            e.dz = edz;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns at the negedge where done is seen, with the number of busy cycles before it
    task automatic wait_done(output int nb);
        bit seen;
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) nb++;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done in 80 cycles expected done");
        end
    endtask

    task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq,
                          input logic [31:0] er, input logic edz);
        int nb;
        @(negedge clk);
        issue(sgn, a, b, 1'b1, eq, er, edz);
        wait_done(nb);
        check({"busy_cycles_", name}, 32'(nb), 32'd33);
    endtask

    initial begin
        int nb;
        int n_done;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;

        run_op("u100_7",   1'b0, 32'd100,       32'd7,          32'd14,        32'd2,         1'b0);
        run_op("s-7_2",    1'b1, 32'hFFFFFFF9,  32'h00000002,   32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0);
        run_op("s7_-2",    1'b1, 32'h00000007,  32'hFFFFFFFE,   32'hFFFFFFFD,  32'h00000001,  1'b0);
        run_op("s-100_-7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,   32'd14,        32'hFFFFFFFE,  1'b0);
        run_op("u_big",    1'b0, 32'hFFFFFFFF,  32'h80000000,   32'd1,         32'h7FFFFFFF,  1'b0);
        run_op("u_dz",     1'b0, 32'h12345678,  32'd0,          32'hFFFFFFFF,  32'h12345678,  1'b1);
        run_op("s_dz",     1'b1, 32'h12345678,  32'd0,          32'hFFFFFFFF,  32'h12345678,  1'b1);

        // Most-negative by -1 wraps, then a new op is started in the done cycle
        run_op("s_min_-1", 1'b1, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,  32'd0,         1'b0);
        issue(1'b0, 32'hFFFFFFFF, 32'd1, 1'b1, 32'hFFFFFFFF, 32'd0, 1'b0);
        wait_done(nb);
        check("busy_cycles_b2b", 32'(nb), 32'd33);

        // A second start during RUN must be ignored
        @(negedge clk);
        issue(1'b0, 32'd1000, 32'd10, 1'b1, 32'd100, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        issue(1'b0, 32'd55, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0);
        wait_done(nb);
        check("busy_cycles_ignored", 32'(nb), 32'd29);

        // Reset mid-operation aborts without a done pulse
        @(negedge clk);
        issue(1'b0, 32'd77, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);

        run_op("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        repeat (2) @(negedge clk);
        check("pending_results", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
